// File: rtl/axil_timer_cfg_seq_pkg.sv
// Shared types and constants for the AXI4-Lite timer configuration sequencer.
package axil_timer_cfg_pkg;

    localparam int unsigned NUM_REGS = 4;
    localparam int unsigned REG_W    = 32;
    localparam int unsigned IDX_W    = 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        DONE    = 3'd5
    } state_e;

    typedef logic [1:0] resp_t;
    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;

    typedef logic [1:0] err_code_t;
    localparam err_code_t ERR_NONE  = 2'b00;
    localparam err_code_t ERR_BRESP = 2'b01;
    localparam err_code_t ERR_RRESP = 2'b10;
    localparam err_code_t ERR_CMP   = 2'b11;

endpackage

// File: rtl/axil_timer_cfg_seq_if.sv
// AXI4-Lite bus bundle between the configuration sequencer (master) and the timer IP (slave).
interface axil_timer_cfg_seq_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0]   AWADDR;
    logic [2:0]          AWPROT;
    logic                AWVALID;
    logic                AWREADY;
    logic [DATA_W-1:0]   WDATA;
    logic [DATA_W/8-1:0] WSTRB;
    logic                WVALID;
    logic                WREADY;
    logic [1:0]          BRESP;
    logic                BVALID;
    logic                BREADY;
    logic [ADDR_W-1:0]   ARADDR;
    logic [2:0]          ARPROT;
    logic                ARVALID;
    logic                ARREADY;
    logic [DATA_W-1:0]   RDATA;
    logic [1:0]          RRESP;
    logic                RVALID;
    logic                RREADY;

    modport master (
        output AWADDR, AWPROT, AWVALID, input AWREADY,
        output WDATA, WSTRB, WVALID, input WREADY,
        input BRESP, BVALID, output BREADY,
        output ARADDR, ARPROT, ARVALID, input ARREADY,
        input RDATA, RRESP, RVALID, output RREADY
    );

    modport slave (
        input AWADDR, AWPROT, AWVALID, output AWREADY,
        input WDATA, WSTRB, WVALID, output WREADY,
        output BRESP, BVALID, input BREADY,
        input ARADDR, ARPROT, ARVALID, output ARREADY,
        output RDATA, RRESP, RVALID, input RREADY
    );
endinterface

// File: rtl/axil_timer_cfg_seq.sv
// Programs the four timer registers over AXI4-Lite after a start pulse, then reads
// them back and reports the first response or compare error.
module axil_timer_cfg_seq
    import axil_timer_cfg_pkg::*;
#(
    parameter int unsigned                  C_M_AXI_ADDR_WIDTH = 32,
    parameter int unsigned                  C_M_AXI_DATA_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR          = '0
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    input  logic                      start,
    input  logic [NUM_REGS*REG_W-1:0] cfg_data,
    input  logic [NUM_REGS-1:0]       cmp_en,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [IDX_W-1:0]          err_idx,
    output logic [1:0]                err_code,
    axil_timer_cfg_seq_if.master      m_axi
);

    localparam int unsigned AW = C_M_AXI_ADDR_WIDTH;
    localparam int unsigned DW = C_M_AXI_DATA_WIDTH;

    function automatic logic [AW-1:0] reg_addr(input logic [IDX_W-1:0] i);
        return BASE_ADDR + AW'({i, 2'b00});
    endfunction

    function automatic logic [DW-1:0] cfg_word(input logic [NUM_REGS*REG_W-1:0] c,
                                               input logic [IDX_W-1:0]          i);
        return DW'(c[REG_W*i +: REG_W]);
    endfunction

    state_e state_q, state_d;

    logic [NUM_REGS*REG_W-1:0] cfg_q, cfg_d;
    logic [NUM_REGS-1:0]       cmp_q, cmp_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic                      aw_done_q, aw_done_d;
    logic                      w_done_q, w_done_d;
    logic                      awvalid_q, awvalid_d;
    logic                      wvalid_q, wvalid_d;
    logic                      bready_q, bready_d;
    logic                      arvalid_q, arvalid_d;
    logic                      rready_q, rready_d;
    logic [AW-1:0]             awaddr_q, awaddr_d;
    logic [DW-1:0]             wdata_q, wdata_d;
    logic [AW-1:0]             araddr_q, araddr_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      err_q, err_d;
    logic [IDX_W-1:0]          err_idx_q, err_idx_d;
    err_code_t                 err_code_q, err_code_d;

    // Handshake events and per-beat decisions shared by both comb processes
    logic             aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic             aw_ok, w_ok, wr_both;
    logic             b_bad, r_bad, r_miss, last;
    logic [IDX_W-1:0] idx_inc;

    always_comb begin
        aw_hs   = awvalid_q & m_axi.AWREADY;
        w_hs    = wvalid_q & m_axi.WREADY;
        b_hs    = bready_q & m_axi.BVALID;
        ar_hs   = arvalid_q & m_axi.ARREADY;
        r_hs    = rready_q & m_axi.RVALID;
        aw_ok   = aw_done_q | aw_hs;
        w_ok    = w_done_q | w_hs;
        wr_both = aw_ok & w_ok;
        b_bad   = (m_axi.BRESP != RESP_OKAY);
        r_bad   = (m_axi.RRESP != RESP_OKAY);
        r_miss  = cmp_q[idx_q] && (m_axi.RDATA != cfg_word(cfg_q, idx_q));
        last    = (idx_q == IDX_W'(NUM_REGS - 1));
        idx_inc = idx_q + IDX_W'(1);
    end

    // State register
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: state_d = start ? WR_REQ : IDLE;
            WR_REQ:     if (wr_both) state_d = WR_RESP;
            WR_RESP: begin
                if (b_hs) begin
                    if (b_bad)     state_d = DONE;
                    else if (last) state_d = RD_REQ;
                    else           state_d = WR_REQ;
                end
            end
            RD_REQ:     if (ar_hs) state_d = RD_RESP;
            RD_RESP: begin
                if (r_hs) begin
                    if (r_bad || r_miss || last) state_d = DONE;
                    else                         state_d = RD_REQ;
                end
            end
            default:    state_d = IDLE;
        endcase
    end

    // Output and datapath next values; every output is a flop loaded from here
    always_comb begin
        cfg_d      = cfg_q;
        cmp_d      = cmp_q;
        idx_d      = idx_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        bready_d   = bready_q;
        arvalid_d  = arvalid_q;
        rready_d   = rready_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        araddr_d   = araddr_q;
        busy_d     = busy_q;
        done_d     = done_q;
        err_d      = err_q;
        err_idx_d  = err_idx_q;
        err_code_d = err_code_q;

        case (state_q)
            IDLE, DONE: begin
                done_d = 1'b0;
                busy_d = 1'b0;
                if (start) begin
                    cfg_d      = cfg_data;
                    cmp_d      = cmp_en;
                    err_d      = 1'b0;
                    err_idx_d  = '0;
                    err_code_d = ERR_NONE;
                    idx_d      = '0;
                    busy_d     = 1'b1;
                    awvalid_d  = 1'b1;
                    wvalid_d   = 1'b1;
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                    awaddr_d   = reg_addr('0);
                    wdata_d    = cfg_word(cfg_data, '0);
                end
            end
            WR_REQ: begin
                // AW and W retire independently; B is only opened once both have
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if (wr_both) bready_d = 1'b1;
            end
            WR_RESP: begin
                if (b_hs) begin
                    bready_d = 1'b0;
                    if (b_bad) begin
                        err_d      = 1'b1;
                        err_idx_d  = idx_q;
                        err_code_d = ERR_BRESP;
                        done_d     = 1'b1;
                    end else if (last) begin
                        idx_d     = '0;
                        arvalid_d = 1'b1;
                        araddr_d  = reg_addr('0);
                    end else begin
                        idx_d     = idx_inc;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        awaddr_d  = reg_addr(idx_inc);
                        wdata_d   = cfg_word(cfg_q, idx_inc);
                    end
                end
            end
            RD_REQ: begin
                if (ar_hs) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            RD_RESP: begin
                if (r_hs) begin
                    rready_d = 1'b0;
                    if (r_bad) begin
                        err_d      = 1'b1;
                        err_idx_d  = idx_q;
                        err_code_d = ERR_RRESP;
                        done_d     = 1'b1;
                    end else if (r_miss) begin
                        err_d      = 1'b1;
                        err_idx_d  = idx_q;
                        err_code_d = ERR_CMP;
                        done_d     = 1'b1;
                    end else if (last) begin
                        done_d = 1'b1;
                    end else begin
                        idx_d     = idx_inc;
                        arvalid_d = 1'b1;
                        araddr_d  = reg_addr(idx_inc);
                    end
                end
            end
            default: begin
                busy_d = 1'b0;
                done_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            cfg_q      <= '0;
            cmp_q      <= '0;
            idx_q      <= '0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            araddr_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_idx_q  <= '0;
            err_code_q <= ERR_NONE;
        end else begin
            cfg_q      <= cfg_d;
            cmp_q      <= cmp_d;
            idx_q      <= idx_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            bready_q   <= bready_d;
            arvalid_q  <= arvalid_d;
            rready_q   <= rready_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            araddr_q   <= araddr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_idx_q  <= err_idx_d;
            err_code_q <= err_code_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign err_idx  = err_idx_q;
    assign err_code = err_code_q;

    assign m_axi.AWADDR  = awaddr_q;
    assign m_axi.AWPROT  = 3'b000;
    assign m_axi.AWVALID = awvalid_q;
    assign m_axi.WDATA   = wdata_q;
    assign m_axi.WSTRB   = '1;
    assign m_axi.WVALID  = wvalid_q;
    assign m_axi.BREADY  = bready_q;
    assign m_axi.ARADDR  = araddr_q;
    assign m_axi.ARPROT  = 3'b000;
    assign m_axi.ARVALID = arvalid_q;
    assign m_axi.RREADY  = rready_q;

endmodule

// File: tb/tb_axil_timer_cfg_seq.sv
// Randomised bench for axil_timer_cfg_seq: a configurable AXI4-Lite slave plus a
// sequence-level reference model of writes, reads, errors and completion time.
module tb_axil_timer_cfg_seq;

    localparam logic [31:0] BASE = 32'h4000_0000;

    logic         ACLK    = 1'b0;
    logic         ARESETN = 1'b0;
    logic         start   = 1'b0;
    logic [127:0] cfg_data = '0;
    logic [3:0]   cmp_en   = '0;
    logic         busy, done, err;
    logic [1:0]   err_idx, err_code;

    axil_timer_cfg_seq_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    axil_timer_cfg_seq #(
        .C_M_AXI_ADDR_WIDTH(32),
        .C_M_AXI_DATA_WIDTH(32),
        .BASE_ADDR(BASE)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .start(start),
        .cfg_data(cfg_data), .cmp_en(cmp_en),
        .busy(busy), .done(done), .err(err),
        .err_idx(err_idx), .err_code(err_code),
        .m_axi(bus)
    );

    always #5 ACLK = ~ACLK;

    int vectors = 0;
    int miscompares = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Slave behaviour knobs (index 4 means "no fault")
    int          aw_dly = 0, w_dly = 0, ar_dly = 0;
    int          bad_b = 4, bad_r = 4, cor_idx = 4;
    logic [31:0] cor_val = '0;
    bit          r_stall = 1'b0;

    // Slave state and bus monitor
    logic [31:0] mem [4];
    logic [31:0] aw_a, w_d, ar_a;
    bit          got_aw, got_w, got_ar, b_drv, b_fire, r_drv, r_fire;
    int          aw_wait, w_wait, ar_wait, aw_run, w_run, ar_run;
    int          bviol = 0;
    logic [31:0] mon_aw[$], mon_w[$], mon_ar[$];
    int          aw_run_q[$], w_run_q[$], ar_run_q[$];

    always @(negedge ACLK) begin
        if (!ARESETN) begin
            b_drv = 0; b_fire = 0; r_drv = 0; r_fire = 0;
            got_aw = 0; got_w = 0; got_ar = 0;
            aw_wait = 0; w_wait = 0; ar_wait = 0;
            aw_run = 0; w_run = 0; ar_run = 0;
            bus.AWREADY = 0; bus.WREADY = 0; bus.ARREADY = 0;
            bus.BVALID = 0; bus.BRESP = 2'b00;
            bus.RVALID = 0; bus.RRESP = 2'b00; bus.RDATA = '0;
        end else begin
            // Responses open the cycle after their request handshakes
            if (b_fire) b_drv = 0;
            b_fire = 0;
            if (!b_drv && got_aw && got_w) begin
                b_drv = 1; got_aw = 0; got_w = 0;
                mem[aw_a[3:2]] = w_d;
                bus.BRESP = (int'(aw_a[3:2]) == bad_b) ? 2'b10 : 2'b00;
            end
            bus.BVALID = b_drv;
            if (b_drv && bus.BREADY) b_fire = 1;

            if (r_fire) r_drv = 0;
            r_fire = 0;
            if (!r_drv && got_ar && !r_stall) begin
                r_drv = 1; got_ar = 0;
                bus.RDATA = (int'(ar_a[3:2]) == cor_idx) ? cor_val : mem[ar_a[3:2]];
                bus.RRESP = (int'(ar_a[3:2]) == bad_r) ? 2'b10 : 2'b00;
            end
            bus.RVALID = r_drv;
            if (r_drv && bus.RREADY) r_fire = 1;

            if (bus.BREADY && (bus.AWVALID || bus.WVALID)) bviol++;

            bus.AWREADY = 0;
            if (bus.AWVALID) begin
                aw_run++;
                if (aw_wait >= aw_dly) begin
                    bus.AWREADY = 1; got_aw = 1; aw_a = bus.AWADDR; aw_wait = 0;
                    mon_aw.push_back(bus.AWADDR);
                end else aw_wait++;
            end else if (aw_run != 0) begin
                aw_run_q.push_back(aw_run); aw_run = 0;
            end

            bus.WREADY = 0;
            if (bus.WVALID) begin
                w_run++;
                if (w_wait >= w_dly) begin
                    bus.WREADY = 1; got_w = 1; w_d = bus.WDATA; w_wait = 0;
                    mon_w.push_back(bus.WDATA);
                end else w_wait++;
            end else if (w_run != 0) begin
                w_run_q.push_back(w_run); w_run = 0;
            end

            bus.ARREADY = 0;
            if (bus.ARVALID) begin
                ar_run++;
                if (ar_wait >= ar_dly) begin
                    bus.ARREADY = 1; got_ar = 1; ar_a = bus.ARADDR; ar_wait = 0;
                    mon_ar.push_back(bus.ARADDR);
                end else ar_wait++;
            end else if (ar_run != 0) begin
                ar_run_q.push_back(ar_run); ar_run = 0;
            end
        end
    end

    // Sequence-level expectation from the register values, enables and slave knobs
    task automatic model(input logic [127:0] cfg, input logic [3:0] cmp,
                         output int e, output int eidx, output int ecode,
                         output int nw, output int nr, output int cyc);
        logic [31:0] word, rd;
        e = 0; eidx = 0; ecode = 0; nw = 0; nr = 0; cyc = 1;
        for (int i = 0; i < 4 && e == 0; i++) begin
            nw++;
            cyc += ((aw_dly > w_dly) ? aw_dly : w_dly) + 2;
            if (i == bad_b) begin e = 1; eidx = i; ecode = 1; end
        end
        for (int i = 0; i < 4 && e == 0; i++) begin
            nr++;
            cyc += ar_dly + 2;
            word = cfg[32*i +: 32];
            rd   = (i == cor_idx) ? cor_val : word;
            if (i == bad_r)                 begin e = 1; eidx = i; ecode = 2; end
            else if (cmp[i] && rd != word)  begin e = 1; eidx = i; ecode = 3; end
        end
    endtask

    task automatic knobs_clear();
        aw_dly = 0; w_dly = 0; ar_dly = 0;
        bad_b = 4; bad_r = 4; cor_idx = 4; cor_val = '0; r_stall = 0;
    endtask

    task automatic run_seq(input logic [127:0] cfg, input logic [3:0] cmp);
        int e, eidx, ecode, nw, nr, cyc, c, b_aw, b_w, b_ar, b_awr, b_wr, b_arr, b_v, n;
        bit seen;
        model(cfg, cmp, e, eidx, ecode, nw, nr, cyc);
        b_aw = mon_aw.size(); b_w = mon_w.size(); b_ar = mon_ar.size();
        b_awr = aw_run_q.size(); b_wr = w_run_q.size(); b_arr = ar_run_q.size();
        b_v = bviol;
        @(negedge ACLK);
        cfg_data = cfg; cmp_en = cmp; start = 1'b1;
        @(negedge ACLK);
        start = 1'b0; c = 1;
        check_val("busy_c1", 32'(busy), 32'd1);
        check_val("awvalid_c1", 32'(bus.AWVALID), 32'd1);
        seen = 0;
        while (!seen && c < 2000) begin
            if (done) seen = 1;
            else begin @(negedge ACLK); c++; end
        end
        check_val("done_seen", 32'(seen), 32'd1);
        check_val("done_cycle", 32'(c), 32'(cyc));
        check_val("err", 32'(err), 32'(e));
        check_val("err_idx", 32'(err_idx), 32'(eidx));
        check_val("err_code", 32'(err_code), 32'(ecode));
        check_val("busy_at_done", 32'(busy), 32'd1);
        @(negedge ACLK);
        check_val("busy_after", 32'(busy), 32'd0);
        check_val("done_pulse", 32'(done), 32'd0);
        check_val("err_sticky", 32'(err), 32'(e));
        check_val("n_writes", 32'(mon_aw.size() - b_aw), 32'(nw));
        check_val("n_wdata", 32'(mon_w.size() - b_w), 32'(nw));
        check_val("n_reads", 32'(mon_ar.size() - b_ar), 32'(nr));
        check_val("bready_early", 32'(bviol - b_v), 32'd0);
        n = mon_aw.size() - b_aw;
        for (int i = 0; i < n && i < nw; i++) begin
            check_val("awaddr", mon_aw[b_aw + i], BASE + 32'(4 * i));
            check_val("wdata", mon_w[b_w + i], cfg[32*i +: 32]);
            check_val("aw_valid_len", 32'(aw_run_q[b_awr + i]), 32'(aw_dly + 1));
            check_val("w_valid_len", 32'(w_run_q[b_wr + i]), 32'(w_dly + 1));
        end
        n = mon_ar.size() - b_ar;
        for (int i = 0; i < n && i < nr; i++) begin
            check_val("araddr", mon_ar[b_ar + i], BASE + 32'(4 * i));
            check_val("ar_valid_len", 32'(ar_run_q[b_arr + i]), 32'(ar_dly + 1));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_awvalid"}, 32'(bus.AWVALID), 32'd0);
        check_val({tag, "_wvalid"}, 32'(bus.WVALID), 32'd0);
        check_val({tag, "_bready"}, 32'(bus.BREADY), 32'd0);
        check_val({tag, "_arvalid"}, 32'(bus.ARVALID), 32'd0);
        check_val({tag, "_rready"}, 32'(bus.RREADY), 32'd0);
        check_val({tag, "_awaddr"}, bus.AWADDR, 32'd0);
        check_val({tag, "_wdata"}, bus.WDATA, 32'd0);
        check_val({tag, "_araddr"}, bus.ARADDR, 32'd0);
        check_val({tag, "_busy"}, 32'(busy), 32'd0);
        check_val({tag, "_done"}, 32'(done), 32'd0);
        check_val({tag, "_err"}, 32'(err), 32'd0);
        check_val({tag, "_err_idx"}, 32'(err_idx), 32'd0);
        check_val({tag, "_err_code"}, 32'(err_code), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] cfg;
        int c, ndone, d1, d2, b_aw;
        bit rr;

        knobs_clear();
        repeat (3) @(negedge ACLK);
        check_reset_outputs("reset");
        check_val("reset_awprot", 32'(bus.AWPROT), 32'd0);
        check_val("reset_wstrb", 32'(bus.WSTRB), 32'hF);
        ARESETN = 1'b1;
        repeat (2) @(negedge ACLK);

        // Basic always-ready sequence
        run_seq({32'h4, 32'h3, 32'h2, 32'h1}, 4'hF);

        // AW delayed, W immediate
        aw_dly = 3;
        run_seq({32'hCAFE_0004, 32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001}, 4'hF);
        knobs_clear();

        // SLVERR on write 2
        bad_b = 2;
        run_seq({32'h44, 32'h33, 32'h22, 32'h11}, 4'hF);
        knobs_clear();

        // Read 1 corrupted: masked, then compared
        cor_idx = 1; cor_val = 32'hDEAD;
        run_seq({32'h1004, 32'h1003, 32'h1002, 32'h1001}, 4'b1101);
        run_seq({32'h1004, 32'h1003, 32'h1002, 32'h1001}, 4'hF);
        knobs_clear();

        // RRESP error on read 3
        bad_r = 3;
        run_seq({32'h5, 32'h6, 32'h7, 32'h8}, 4'h0);
        knobs_clear();

        // Reset while RD_RESP is waiting
        r_stall = 1;
        @(negedge ACLK);
        cfg_data = {32'hA4, 32'hA3, 32'hA2, 32'hA1}; cmp_en = 4'hF; start = 1'b1;
        @(negedge ACLK);
        start = 1'b0; c = 0;
        while (!bus.RREADY && c < 200) begin @(negedge ACLK); c++; end
        rr = bus.RREADY;
        check_val("rst_reached_rd_resp", 32'(rr), 32'd1);
        #2 ARESETN = 1'b0;
        #1 check_reset_outputs("midrst");
        @(negedge ACLK);
        r_stall = 0;
        @(negedge ACLK);
        ARESETN = 1'b1;
        @(negedge ACLK);
        run_seq({32'hB4, 32'hB3, 32'hB2, 32'hB1}, 4'hF);

        // start held high: back-to-back sequences only
        b_aw = mon_aw.size();
        @(negedge ACLK);
        cfg_data = {32'hC4, 32'hC3, 32'hC2, 32'hC1}; cmp_en = 4'hF; start = 1'b1;
        c = 0; ndone = 0; d1 = 0; d2 = 0;
        while (ndone < 2 && c < 200) begin
            @(negedge ACLK); c++;
            if (done) begin
                ndone++;
                if (ndone == 1) d1 = c;
                else begin d2 = c; start = 1'b0; end
            end
            if (c == 18) check_val("held_busy_c18", 32'(busy), 32'd1);
        end
        check_val("held_done1", 32'(d1), 32'd17);
        check_val("held_done2", 32'(d2), 32'd34);
        check_val("held_writes", 32'(mon_aw.size() - b_aw), 32'd8);
        @(negedge ACLK);
        check_val("held_busy_end", 32'(busy), 32'd0);

        // Randomised sequences
        for (int t = 0; t < 30; t++) begin
            knobs_clear();
            cfg = {$urandom, $urandom, $urandom, $urandom};
            aw_dly = $urandom_range(0, 3);
            w_dly  = $urandom_range(0, 3);
            ar_dly = $urandom_range(0, 3);
            case ($urandom_range(0, 3))
                1: bad_b = $urandom_range(0, 3);
                2: bad_r = $urandom_range(0, 3);
                3: begin cor_idx = $urandom_range(0, 3); cor_val = $urandom; end
                default: ;
            endcase
            run_seq(cfg, 4'($urandom_range(0, 15)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
